// File: rtl/handshake_responder.sv
// handshake_responder
//   Responder side of a four-phase req/ack handshake. A rising edge on req starts a
//   fixed ACK_DELAY-cycle wait. After the wait, ack and enable assert and the response
//   word is captured onto data. ack drops when req is withdrawn. Completed handshakes
//   and early withdrawals are counted for debug readout.
//
// Ports
//   clk          in   single clock; all state changes on its rising edge
//   rst          in   synchronous, active-high reset
//   req          in   request level from the initiator
//   rsp_data     in   response word, captured on the edge that raises ack
//   ack          out  acknowledge (registered)
//   enable       out  data-qualify strobe; always equal to ack
//   data         out  captured response word; held between handshakes
//   busy         out  high while a handshake is pending or acknowledged
//   hs_count     out  completed handshakes, wraps modulo 2^CNT_W
//   abort_count  out  requests withdrawn before ack, saturates at 255

module handshake_responder #(
  parameter int unsigned ACK_DELAY = 2,  // legal range 2..15
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [DATA_W-1:0] rsp_data,
  output logic              ack,
  output logic              enable,
  output logic [DATA_W-1:0] data,
  output logic              busy,
  output logic [CNT_W-1:0]  hs_count,
  output logic [7:0]        abort_count
);

  typedef enum logic [1:0] {StIdle, StWait, StAck} state_e;

  // One wait cycle is spent in IDLE->WAIT and one in WAIT->ACK, hence the -2.
  localparam logic [3:0] CntInit = 4'(ACK_DELAY - 2);

  state_e            state_q, state_d;
  logic              req_q;
  logic [3:0]        cnt_q, cnt_d;
  logic              ack_q, ack_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]  hs_q, hs_d;
  logic [7:0]        abort_q, abort_d;
  logic              rise;

  assign rise = req & ~req_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      req_q   <= 1'b0;
      cnt_q   <= 4'd0;
      ack_q   <= 1'b0;
      data_q  <= '0;
      hs_q    <= '0;
      abort_q <= 8'd0;
    end else begin
      state_q <= state_d;
      req_q   <= req;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      data_q  <= data_d;
      hs_q    <= hs_d;
      abort_q <= abort_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (rise) begin
          state_d = StWait;
          cnt_d   = CntInit;
        end
      end
      StWait: begin
        // Withdrawal wins over an expiring count.
        if (!req) begin
          state_d = StIdle;
        end else if (cnt_q == 4'd0) begin
          state_d = StAck;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StAck: begin
        if (!req) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output / datapath logic
  always_comb begin
    ack_d   = ack_q;
    data_d  = data_q;
    hs_d    = hs_q;
    abort_d = abort_q;
    busy    = (state_q != StIdle);
    unique case (state_q)
      StIdle: ack_d = 1'b0;
      StWait: begin
        if (!req) begin
          ack_d = 1'b0;
          if (abort_q != 8'hFF) begin
            abort_d = abort_q + 8'd1;
          end
        end else if (cnt_q == 4'd0) begin
          ack_d  = 1'b1;
          data_d = rsp_data;
        end
      end
      StAck: begin
        if (!req) begin
          ack_d = 1'b0;
          hs_d  = hs_q + CNT_W'(1);
        end
      end
      default: ack_d = 1'b0;
    endcase
  end

  assign ack         = ack_q;
  assign enable      = ack_q;
  assign data        = data_q;
  assign hs_count    = hs_q;
  assign abort_count = abort_q;

endmodule

// File: tb/tb_handshake_responder.sv
module tb_handshake_responder;

  logic        clk;
  logic        rst;
  logic        req;
  logic [7:0]  rsp_data;
  logic        ack;
  logic        enable;
  logic [7:0]  data;
  logic        busy;
  logic [15:0] hs_count;
  logic [7:0]  abort_count;

  logic        req5;
  logic [7:0]  rsp5;
  logic        ack5;
  logic        en5;
  logic [7:0]  data5;
  logic        busy5;
  logic [1:0]  hs5;
  logic [7:0]  abort5;

  int n_checks = 0;
  int n_errors = 0;

  handshake_responder dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .rsp_data   (rsp_data),
    .ack        (ack),
    .enable     (enable),
    .data       (data),
    .busy       (busy),
    .hs_count   (hs_count),
    .abort_count(abort_count)
  );

  // Longer delay and a 2-bit counter so wrap is reachable in a few handshakes.
  handshake_responder #(
    .ACK_DELAY(5),
    .DATA_W   (8),
    .CNT_W    (2)
  ) dut5 (
    .clk        (clk),
    .rst        (rst),
    .req        (req5),
    .rsp_data   (rsp5),
    .ack        (ack5),
    .enable     (en5),
    .data       (data5),
    .busy       (busy5),
    .hs_count   (hs5),
    .abort_count(abort5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are then stable and reflect that edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_main(input string tag, input logic a, input logic [7:0] d,
                            input logic b, input logic [15:0] hs, input logic [7:0] ab);
    check({tag, ".ack"}, 32'(ack), 32'(a));
    check({tag, ".enable"}, 32'(enable), 32'(a));
    check({tag, ".data"}, 32'(data), 32'(d));
    check({tag, ".busy"}, 32'(busy), 32'(b));
    check({tag, ".hs"}, 32'(hs_count), 32'(hs));
    check({tag, ".abort"}, 32'(abort_count), 32'(ab));
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; rsp_data = 8'h00; req5 = 1'b0; rsp5 = 8'h00;
    tick();
    tick();
    check_main("reset", 1'b0, 8'h00, 1'b0, 16'd0, 8'd0);
    rst = 1'b0;
    tick();

    // Basic handshake
    rsp_data = 8'hA5; req = 1'b1;
    tick();  // rise sampled
    check_main("basic_wait", 1'b0, 8'h00, 1'b1, 16'd0, 8'd0);
    tick();  // ack raised, sampled high at next edge
    check_main("basic_ack", 1'b1, 8'hA5, 1'b1, 16'd0, 8'd0);
    rsp_data = 8'h11;  // must not disturb held data
    repeat (6) tick();
    check_main("basic_hold", 1'b1, 8'hA5, 1'b1, 16'd0, 8'd0);
    req = 1'b0;
    tick();
    check_main("basic_rel", 1'b0, 8'hA5, 1'b0, 16'd1, 8'd0);
    tick();

    // Abort while counter already at zero
    req = 1'b1;
    tick();
    check("abort_wait.busy", 32'(busy), 32'd1);
    req = 1'b0;
    tick();
    check_main("abort", 1'b0, 8'hA5, 1'b0, 16'd1, 8'd1);
    tick();
    check_main("abort_idle", 1'b0, 8'hA5, 1'b0, 16'd1, 8'd1);

    // Back-to-back: release then re-request on the very next edge
    rsp_data = 8'h77; req = 1'b1;
    tick();
    tick();
    check("b2b_first.data", 32'(data), 32'h77);
    req = 1'b0; rsp_data = 8'h3C;
    tick();  // release edge F
    check_main("b2b_rel", 1'b0, 8'h77, 1'b0, 16'd2, 8'd1);
    req = 1'b1;
    tick();  // F+1: accepted as a rise
    check_main("b2b_rise", 1'b0, 8'h77, 1'b1, 16'd2, 8'd1);
    tick();
    check_main("b2b_ack", 1'b1, 8'h3C, 1'b1, 16'd2, 8'd1);
    req = 1'b0;
    tick();
    check_main("b2b_rel2", 1'b0, 8'h3C, 1'b0, 16'd3, 8'd1);

    // Reset in the middle of ACK with req held high
    rsp_data = 8'h5A; req = 1'b1;
    tick();
    tick();
    check("pre_rst.ack", 32'(ack), 32'd1);
    rst = 1'b1;
    tick();
    check_main("mid_rst", 1'b0, 8'h00, 1'b0, 16'd0, 8'd0);
    rst = 1'b0;
    tick();  // req high, req_q cleared: counts as a rise
    check_main("post_rst_rise", 1'b0, 8'h00, 1'b1, 16'd0, 8'd0);
    tick();
    check_main("post_rst_ack", 1'b1, 8'h5A, 1'b1, 16'd0, 8'd0);
    req = 1'b0;
    tick();
    check_main("post_rst_rel", 1'b0, 8'h5A, 1'b0, 16'd1, 8'd0);

    // ACK_DELAY=5 latency
    rsp5 = 8'hC3; req5 = 1'b1;
    tick();  // rise at edge T
    tick();
    tick();
    tick();  // T+3
    check("d5_t3.ack", 32'(ack5), 32'd0);
    check("d5_t3.busy", 32'(busy5), 32'd1);
    tick();  // T+4: ack visible, sampled high at T+5
    check("d5_t4.ack", 32'(ack5), 32'd1);
    check("d5_t4.enable", 32'(en5), 32'd1);
    check("d5_t4.data", 32'(data5), 32'hC3);
    req5 = 1'b0;
    tick();
    check("d5_rel.hs", 32'(hs5), 32'd1);
    check("d5_rel.ack", 32'(ack5), 32'd0);

    // Three more handshakes wrap the 2-bit counter 1->2->3->0
    for (int i = 0; i < 3; i++) begin
      rsp5 = 8'(i + 1); req5 = 1'b1;
      repeat (5) tick();
      check("d5_loop.ack", 32'(ack5), 32'd1);
      req5 = 1'b0;
      tick();
    end
    check("d5_wrap.hs", 32'(hs5), 32'd0);
    check("d5_wrap.data", 32'(data5), 32'd3);

    // 300 aborts with counter non-zero: saturates at 255
    for (int i = 0; i < 300; i++) begin
      req5 = 1'b1;
      tick();
      req5 = 1'b0;
      tick();
      if (i == 0) check("d5_abort1", 32'(abort5), 32'd1);
      if (i == 253) check("d5_abort254", 32'(abort5), 32'd254);
    end
    check("d5_sat.abort", 32'(abort5), 32'd255);
    check("d5_sat.ack", 32'(ack5), 32'd0);
    check("d5_sat.data", 32'(data5), 32'd3);
    check("d5_sat.busy", 32'(busy5), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
